// File: rtl/ad5328_ctrl.sv
// ad5328_ctrl: init sequencer and round-robin channel scheduler for the AD5328 serial core
module ad5328_ctrl #(
    parameter logic [15:0] INIT_WORD0   = 16'hE000,
    parameter logic [15:0] INIT_WORD1   = 16'h8000,
    parameter logic [15:0] INIT_WORD2   = 16'hA000,
    parameter logic [11:0] DEFAULT_CODE = 12'h000,
    parameter int          ACK_TIMEOUT  = 16,
    parameter int          DONE_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ch_wr_i,
    input  logic [2:0]  ch_sel_i,
    input  logic [11:0] ch_val_i,
    input  logic        refresh_req_i,
    input  logic        dac_ready_i,
    output logic        dac_wr_req_o,
    output logic [15:0] dac_wr_data_o,
    output logic        init_done_o,
    output logic        busy_o,
    output logic [7:0]  pending_o,
    output logic        err_timeout_o
);
    localparam int CW = $clog2(ACK_TIMEOUT + DONE_TIMEOUT);

    typedef enum logic [2:0] {BOOT, IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t        state_q;
    logic [11:0]   shadow_q [8];
    logic [7:0]    pending_q, pending_d;
    logic [2:0]    last_ch_q, cur_ch_q, sel_ch;
    logic [1:0]    init_idx_q;
    logic          init_done_q, err_q, wr_req_q, busy_q, cur_init_q;
    logic [15:0]   wr_data_q, init_word;
    logic [CW-1:0] cnt_q;
    logic          sel_ok, in_init, timeout, issue_ch, init_fin;

    assign dac_wr_req_o  = wr_req_q;
    assign dac_wr_data_o = wr_data_q;
    assign init_done_o   = init_done_q;
    assign busy_o        = busy_q;
    assign pending_o     = pending_q;
    assign err_timeout_o = err_q;

    // Host writes land in the shadow array in any state; the issued word keeps the value captured at selection
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) shadow_q[i] <= DEFAULT_CODE;
        end else if (ch_wr_i) begin
            shadow_q[ch_sel_i] <= ch_val_i;
        end
    end

    // Round-robin pick: nearest dirty channel after last_ch, wrapping, with last_ch itself searched last
    always_comb begin
        sel_ch = last_ch_q;
        sel_ok = 1'b0;
        for (int k = 8; k >= 1; k--) begin
            if (pending_q[last_ch_q + 3'(k)]) begin
                sel_ch = last_ch_q + 3'(k);
                sel_ok = 1'b1;
            end
        end
    end

    // Word selection, handshake timeouts and the dirty mask; host sets are applied after clears so they are never lost
    always_comb begin
        in_init   = init_idx_q != 2'd3;
        init_word = init_idx_q == 2'd0 ? INIT_WORD0 : init_idx_q == 2'd1 ? INIT_WORD1 : INIT_WORD2;
        timeout   = (state_q == WAIT_ACK && dac_ready_i && cnt_q == CW'(ACK_TIMEOUT - 1)) ||
                    (state_q == WAIT_DONE && !dac_ready_i && cnt_q == CW'(DONE_TIMEOUT - 1));
        issue_ch  = state_q == IDLE && !in_init && sel_ok;
        init_fin  = state_q == WAIT_DONE && dac_ready_i && cur_init_q && init_idx_q == 2'd2;
        pending_d = pending_q;
        if (issue_ch) pending_d[sel_ch] = 1'b0;
        if (timeout && !cur_init_q) pending_d[cur_ch_q] = 1'b1;
        if (init_fin || refresh_req_i) pending_d = 8'hFF;
        if (ch_wr_i) pending_d[ch_sel_i] = 1'b1;
    end

    // Transfer FSM: one word per core transaction, registered request/data/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BOOT;
            pending_q   <= '0;
            last_ch_q   <= 3'd7;
            cur_ch_q    <= '0;
            init_idx_q  <= '0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            wr_req_q    <= 1'b0;
            wr_data_q   <= '0;
            busy_q      <= 1'b1;
            cur_init_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            pending_q <= pending_d;
            case (state_q)
                BOOT: begin
                    if (dac_ready_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (in_init || sel_ok) begin
                        state_q    <= ISSUE;
                        busy_q     <= 1'b1;
                        wr_req_q   <= 1'b1;
                        cur_init_q <= in_init;
                        wr_data_q  <= in_init ? init_word : {1'b0, sel_ch, shadow_q[sel_ch]};
                    end
                    if (issue_ch) begin
                        cur_ch_q  <= sel_ch;
                        last_ch_q <= sel_ch;
                    end
                end
                ISSUE: begin
                    state_q  <= WAIT_ACK;
                    wr_req_q <= 1'b0;
                    cnt_q    <= '0;
                end
                WAIT_ACK: begin
                    if (!dac_ready_i) begin
                        state_q <= WAIT_DONE;
                        cnt_q   <= '0;
                    end else if (timeout) begin
                        state_q <= BOOT;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (dac_ready_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (cur_init_q) init_idx_q <= init_idx_q + 2'd1;
                        if (init_fin) init_done_q <= 1'b1;
                    end else if (timeout) begin
                        state_q <= BOOT;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_ad5328_ctrl.sv
// tb_ad5328_ctrl: directed and randomized checks of ad5328_ctrl against a round-robin reference model
module tb_ad5328_ctrl;
    logic        clk, rst, ch_wr, refresh_req, dac_ready;
    logic [2:0]  ch_sel;
    logic [11:0] ch_val;
    logic        dac_wr_req, init_done, busy, err_timeout;
    logic [15:0] dac_wr_data;
    logic [7:0]  pending;

    int n_pass = 0;
    int n_total = 0;
    int ack_dly = 2;
    int done_dly = 340;
    bit core_hold = 0;

    logic [11:0] ref_shadow [8];
    logic [7:0]  ref_pend;
    int          ref_last;

    ad5328_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ch_wr_i      (ch_wr),
        .ch_sel_i     (ch_sel),
        .ch_val_i     (ch_val),
        .refresh_req_i(refresh_req),
        .dac_ready_i  (dac_ready),
        .dac_wr_req_o (dac_wr_req),
        .dac_wr_data_o(dac_wr_data),
        .init_done_o  (init_done),
        .busy_o       (busy),
        .pending_o    (pending),
        .err_timeout_o(err_timeout)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Serial core model: ready drops ack_dly cycles after a request, rises done_dly cycles later
    initial begin
        dac_ready = 1;
        forever begin
            @(negedge clk);
            if (dac_wr_req && !core_hold) begin
                repeat (ack_dly) @(negedge clk);
                dac_ready = 0;
                repeat (done_dly) @(negedge clk);
                dac_ready = 1;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ref_shadow[i] = 12'h000;
        ref_pend = 8'h00;
        ref_last = 7;
    endtask

    // Next word the scheduler owes: first dirty channel after the last one served
    task automatic nxt(output logic [15:0] w);
        int c;
        logic [2:0] c3;
        c = -1;
        for (int k = 1; k <= 8; k++)
            if (c < 0 && ref_pend[(ref_last + k) % 8]) c = (ref_last + k) % 8;
        if (c < 0) c = 0;
        c3 = 3'(c);
        w = {1'b0, c3, ref_shadow[c]};
        ref_pend[c] = 1'b0;
        ref_last = c;
    endtask

    task automatic wr(input logic [2:0] c, input logic [11:0] v);
        ch_wr = 1; ch_sel = c; ch_val = v;
        ref_shadow[c] = v;
        ref_pend[c] = 1'b1;
        @(negedge clk);
        ch_wr = 0;
    endtask

    task automatic refresh();
        refresh_req = 1;
        ref_pend = 8'hFF;
        @(negedge clk);
        refresh_req = 0;
    endtask

    task automatic wait_word(input string tag, input logic [15:0] exp);
        int n = 0;
        while (!dac_wr_req && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, 32'(dac_wr_req), 1);
        chk(tag, 32'(dac_wr_data), 32'(exp));
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        logic [15:0] w;
        while (ref_pend != 0) begin
            nxt(w);
            wait_word(tag, w);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || pending != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("idle", {23'd0, busy, pending}, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wr_req"}, 32'(dac_wr_req), 0);
        chk({tag, "_wr_data"}, 32'(dac_wr_data), 0);
        chk({tag, "_init_done"}, 32'(init_done), 0);
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_pending"}, 32'(pending), 0);
        chk({tag, "_err"}, 32'(err_timeout), 0);
    endtask

    task automatic init_seq(input string tag);
        logic [15:0] w;
        wait_word({tag, "_w0"}, 16'hE000);
        wait_word({tag, "_w1"}, 16'h8000);
        chk({tag, "_done_early"}, 32'(init_done), 0);
        wait_word({tag, "_w2"}, 16'hA000);
        chk({tag, "_done_inflight"}, 32'(init_done), 0);
        ref_pend = 8'hFF;
        nxt(w);
        wait_word({tag, "_ch"}, w);
        chk({tag, "_done"}, 32'(init_done), 1);
        drain({tag, "_ch"});
    endtask

    initial begin
        logic [15:0] w;
        int t, extra, nops;
        rst = 1; ch_wr = 0; ch_sel = 0; ch_val = 0; refresh_req = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset("rst");
        rst = 0;

        init_seq("boot");
        wait_idle();
        done_dly = 40;

        wr(3'd5, 12'hABC);
        chk("lat_pend_set", 32'(pending[5]), 1);
        chk("lat_req_early", 32'(dac_wr_req), 0);
        @(negedge clk);
        nxt(w);
        chk("lat_req", 32'(dac_wr_req), 1);
        chk("lat_data", 32'(dac_wr_data), 32'(w));
        chk("lat_pend_clr", 32'(pending[5]), 0);
        wait_idle();

        wr(3'd2, 12'h0AA);
        nxt(w);
        wait_word("rr_ch2", w);
        wr(3'd6, 12'h111);
        wr(3'd6, 12'h222);
        wr(3'd1, 12'h333);
        nxt(w);
        wait_word("rr_first", w);
        nxt(w);
        wait_word("rr_second", w);
        extra = 0;
        repeat (100) begin
            @(negedge clk);
            if (dac_wr_req) extra++;
        end
        chk("rr_no_extra", 32'(extra), 0);
        wait_idle();

        wr(3'd3, 12'h010);
        nxt(w);
        wr(3'd3, 12'h0F0);
        chk("col_pend_kept", 32'(pending[3]), 1);
        wait_word("col_old", w);
        nxt(w);
        wait_word("col_new", w);
        wait_idle();

        for (int r = 0; r < 20; r++) begin
            wr(3'($urandom_range(0, 7)), 12'($urandom));
            nxt(w);
            wait_word("rnd_trig", w);
            nops = $urandom_range(0, 5);
            for (int i = 0; i < nops; i++) begin
                if ($urandom_range(0, 5) == 0) refresh();
                else wr(3'($urandom_range(0, 7)), 12'($urandom));
            end
            drain("rnd");
            wait_idle();
        end

        core_hold = 1;
        wr(3'd4, 12'h444);
        nxt(w);
        wait_word("to_word", w);
        t = 1;
        while (!err_timeout && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("to_err", 32'(err_timeout), 1);
        chk("to_window", 32'(t >= 16 && t <= 18), 1);
        chk("to_busy", 32'(busy), 1);
        chk("to_pend", 32'(pending[4]), 1);
        ref_pend[4] = 1'b1;
        core_hold = 0;
        nxt(w);
        wait_word("to_resend", w);
        wait_idle();
        chk("to_sticky", 32'(err_timeout), 1);

        done_dly = 340;
        wr(3'd7, 12'h777);
        nxt(w);
        wait_word("rm_word", w);
        repeat (10) @(negedge clk);
        chk("rm_in_done", {30'd0, busy, dac_ready}, 32'h2);
        rst = 1;
        @(negedge clk);
        chk_reset("rm");
        rst = 0;
        model_reset();
        init_seq("reboot");
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
